// File: rtl/draw_sprite_pkg.sv
// Shared constants for the sprite overlay stage of the VGA pipeline.
package draw_sprite_pkg;
  localparam int unsigned SPRITE_W = 48;
  localparam int unsigned SPRITE_H = 64;
  localparam int unsigned RGB_W    = 12;
  localparam logic [RGB_W-1:0] SPRITE_KEY_COLOR = 12'h0F0;

  localparam int unsigned CNT_W = 11;
  // Timing bundle layout: {hcount, vcount, hsync, vsync, hblnk, vblnk}
  localparam int unsigned TIM_W = 2 * CNT_W + 4;
endpackage

// File: rtl/vga_timing_delay.sv
// N-stage register chain for the VGA timing bundle; also exposes the first stage so
// downstream logic can act on stage-1 blanking.
module vga_timing_delay
  import draw_sprite_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [TIM_W-1:0] din,
  output logic [TIM_W-1:0] first,
  output logic [TIM_W-1:0] dout
);

  logic [TIM_W-1:0] chain [N];

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) chain[i] <= '0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < int'(N); i++) chain[i] <= chain[i-1];
    end
  end

  assign first = chain[0];
  assign dout  = chain[N-1];

endmodule

// File: rtl/draw_sprite.sv
// Overlays the 48x64 sprite ROM onto the background stream with 2-cycle latency.
// Define DRAW_SPRITE_TRANSPARENCY_EN to treat SPRITE_KEY_COLOR pixels as transparent.
module draw_sprite
  import draw_sprite_pkg::*;
#(
  parameter int unsigned XPOS_W = 12,
  parameter int unsigned YPOS_W = 12
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  hcount_in,
  input  logic [CNT_W-1:0]  vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [RGB_W-1:0]  rgb_in,
  input  logic [XPOS_W-1:0] xpos,
  input  logic [YPOS_W-1:0] ypos,
  output logic [11:0]       rom_addr,
  input  logic [RGB_W-1:0]  rom_rgb,
  output logic [CNT_W-1:0]  hcount_out,
  output logic [CNT_W-1:0]  vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [RGB_W-1:0]  rgb_out
);

  // One extra bit so the far edge of the box can never wrap.
  localparam int unsigned XB = ((XPOS_W > CNT_W) ? XPOS_W : CNT_W) + 1;
  localparam int unsigned YB = ((YPOS_W > CNT_W) ? YPOS_W : CNT_W) + 1;

  logic [XPOS_W-1:0] x_lat;
  logic [YPOS_W-1:0] y_lat;
  logic              vblnk_prev;

  always_ff @(posedge pclk) begin
    if (rst) begin
      x_lat      <= '0;
      y_lat      <= '0;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev) begin
        x_lat <= xpos;
        y_lat <= ypos;
      end
    end
  end

  logic [XB-1:0] hc_ext, x_ext, x_end;
  logic [YB-1:0] vc_ext, y_ext, y_end;
  logic          in_sprite_d;
  logic [5:0]    dx, dy;

  always_comb begin
    hc_ext = XB'(hcount_in);
    x_ext  = XB'(x_lat);
    x_end  = x_ext + XB'(SPRITE_W);
    vc_ext = YB'(vcount_in);
    y_ext  = YB'(y_lat);
    y_end  = y_ext + YB'(SPRITE_H);
    in_sprite_d = (hc_ext >= x_ext) && (hc_ext < x_end) &&
                  (vc_ext >= y_ext) && (vc_ext < y_end);
    // Only the low six bits of the offsets reach the ROM address.
    dx = hcount_in[5:0] - x_lat[5:0];
    dy = vcount_in[5:0] - y_lat[5:0];
  end

  logic             in_sprite_q;
  logic [RGB_W-1:0] rgb_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      rom_addr    <= '0;
      in_sprite_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      rom_addr    <= in_sprite_d ? {dy, dx} : 12'h000;
      in_sprite_q <= in_sprite_d;
      rgb_q       <= rgb_in;
    end
  end

  logic [TIM_W-1:0] tim_s1, tim_s2;

  vga_timing_delay #(
    .N (2)
  ) u_timing_delay (
    .pclk  (pclk),
    .rst   (rst),
    .din   ({hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in}),
    .first (tim_s1),
    .dout  (tim_s2)
  );

  logic show_sprite;
`ifdef DRAW_SPRITE_TRANSPARENCY_EN
  assign show_sprite = in_sprite_q && (rom_rgb != SPRITE_KEY_COLOR);
`else
  assign show_sprite = in_sprite_q;
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      rgb_out <= '0;
    end else if (tim_s1[1] || tim_s1[0]) begin
      rgb_out <= '0;
    end else begin
      rgb_out <= show_sprite ? rom_rgb : rgb_q;
    end
  end

  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim_s2;

endmodule

// File: tb/tb_draw_sprite.sv
// Self-checking bench for draw_sprite: directed vector table, corner sequences and
// randomized traffic against a pixel-level reference model.
module tb_draw_sprite;

`ifdef DRAW_SPRITE_TRANSPARENCY_EN
  localparam bit TRANS = 1'b1;
`else
  localparam bit TRANS = 1'b0;
`endif
  localparam logic [11:0] KEY = 12'h0F0;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos;
  logic [11:0] rom_addr, rom_rgb;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  logic [11:0] rom [4096];
  assign rom_rgb = rom[rom_addr];

  always #5 pclk = ~pclk;

  draw_sprite #(
    .XPOS_W (12),
    .YPOS_W (12)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .xpos       (xpos),
    .ypos       (ypos),
    .rom_addr   (rom_addr),
    .rom_rgb    (rom_rgb),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: sprite position, last vblnk, and the pixel presented last cycle.
  typedef struct {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic [11:0] addr;
    bit          inbox;
  } rec_t;

  int   mx, my;
  bit   mvprev;
  rec_t p;

  task automatic clear_prev();
    p.h = 0; p.v = 0; p.hs = 0; p.vs = 0; p.hb = 0; p.vb = 0;
    p.rgb = 0; p.addr = 0; p.inbox = 0;
  endtask

  task automatic tick();
    logic [11:0] a, orgb;
    logic [25:0] otim;
    bit          inbox;
    int          h, v;
    h = int'(hcount_in);
    v = int'(vcount_in);
    if (rst) begin
      a = 0; orgb = 0; otim = 0;
      clear_prev();
      mx = 0; my = 0; mvprev = 0;
    end else begin
      inbox = (h >= mx) && (h < mx + 48) && (v >= my) && (v < my + 64);
      a = inbox ? 12'(((v - my) * 64) + (h - mx)) : 12'h000;
      if (p.hb || p.vb) orgb = 0;
      else if (p.inbox && !(TRANS && rom[p.addr] == KEY)) orgb = rom[p.addr];
      else orgb = p.rgb;
      otim = {p.h, p.v, p.hs, p.vs, p.hb, p.vb};
      if (vblnk_in && !mvprev) begin
        mx = int'(xpos);
        my = int'(ypos);
      end
      mvprev = vblnk_in;
      p.h = hcount_in; p.v = vcount_in; p.hs = hsync_in; p.vs = vsync_in;
      p.hb = hblnk_in; p.vb = vblnk_in; p.rgb = rgb_in; p.addr = a; p.inbox = inbox;
    end
    @(posedge pclk);
    #1;
    check("model_addr", 32'(rom_addr), 32'(a));
    check("model_rgb", 32'(rgb_out), 32'(orgb));
    check("model_timing",
          32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
          32'(otim));
  endtask

  task automatic pixel(input int h, input int v, input logic hb, input logic [11:0] rgb);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    rgb_in    = rgb;
  endtask

  // Blanked filler pixel that lets the previous pixel reach rgb_out.
  task automatic filler();
    pixel(0, 0, 1'b1, 12'hABC);
    tick();
  endtask

  task automatic vblank_pulse();
    pixel(0, 0, 1'b1, 12'h000);
    vblnk_in = 1'b1;
    tick();
    vblnk_in = 1'b0;
    tick();
  endtask

  typedef struct {
    int          h, v;
    logic        hb;
    logic [11:0] rgb;
    logic [11:0] exp_addr;
    int          src;  // 0: black, 1: background, 2: rom, 3: rom unless key colour
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [11:0] want;
    for (int i = 0; i < 4096; i++) rom[i] = 12'($urandom);
    rom[12'h7C5] = KEY;
    if (rom[12'h000] == KEY) rom[12'h000] = 12'h111;
    if (rom[12'hFEF] == KEY) rom[12'hFEF] = 12'h222;
    if (rom[12'h50A] == KEY) rom[12'h50A] = 12'h333;
    if (rom[12'h28A] == KEY) rom[12'h28A] = 12'h444;

    // Sprite at (100,50): origin, far corner, just outside each edge, blanked, interior, key.
    vecs[0] = '{100,  50, 1'b0, 12'h123, 12'h000, 2};
    vecs[1] = '{147, 113, 1'b0, 12'h456, 12'hFEF, 2};
    vecs[2] = '{148, 113, 1'b0, 12'h789, 12'h000, 1};
    vecs[3] = '{ 99,  50, 1'b0, 12'h9AB, 12'h000, 1};
    vecs[4] = '{100,  49, 1'b0, 12'hBCD, 12'h000, 1};
    vecs[5] = '{147, 114, 1'b0, 12'hDEF, 12'h000, 1};
    vecs[6] = '{120,  60, 1'b1, 12'h555, 12'h294, 0};
    vecs[7] = '{110,  70, 1'b0, 12'h666, 12'h50A, 2};
    vecs[8] = '{105,  81, 1'b0, 12'h123, 12'h7C5, 3};

    mx = 0; my = 0; mvprev = 0;
    clear_prev();
    rst = 1'b1;
    hsync_in = 0; vsync_in = 0; vblnk_in = 0;
    xpos = 0; ypos = 0;
    pixel(0, 0, 1'b0, 12'h000);
    tick();
    check("reset_rgb", 32'(rgb_out), 0);
    rst = 1'b0;
    tick();

    // Mid-frame position change must not move the sprite yet.
    xpos = 100; ypos = 50;
    pixel(100, 50, 1'b0, 12'h321);
    tick();
    check("prelatch_addr", 32'(rom_addr), 0);
    filler();
    check("prelatch_rgb", 32'(rgb_out), 32'h321);
    vblank_pulse();

    for (int i = 0; i < 9; i++) begin
      pixel(vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].rgb);
      tick();
      check($sformatf("vec%0d_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
      case (vecs[i].src)
        0:       want = 12'h000;
        1:       want = vecs[i].rgb;
        2:       want = rom[vecs[i].exp_addr];
        default: want = TRANS ? vecs[i].rgb : KEY;
      endcase
      filler();
      check($sformatf("vec%0d_rgb", i), 32'(rgb_out), 32'(want));
    end

    // Right-edge clip at x=1000.
    xpos = 1000; ypos = 0;
    vblank_pulse();
    pixel(1020, 5, 1'b0, 12'h0AA);
    tick();
    check("clip_addr_1020", 32'(rom_addr), 32'h154);
    pixel(1023, 5, 1'b0, 12'h0AB);
    tick();
    check("clip_addr_1023", 32'(rom_addr), 32'h157);
    pixel(10, 6, 1'b0, 12'h0AC);
    tick();
    check("clip_nowrap_addr", 32'(rom_addr), 0);
    filler();
    check("clip_nowrap_rgb", 32'(rgb_out), 32'h0AC);

    // Reset mid-frame, then sprite at the origin until the next vblank rise.
    pixel(500, 300, 1'b0, 12'hFFF);
    rst = 1'b1;
    tick();
    check("midreset_rgb", 32'(rgb_out), 0);
    check("midreset_timing",
          32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 0);
    rst = 1'b0;
    pixel(10, 10, 1'b0, 12'h0CC);
    tick();
    check("postreset_addr", 32'(rom_addr), 32'h28A);
    filler();
    check("postreset_rgb", 32'(rgb_out), 32'(rom[12'h28A]));

    // Randomized traffic biased around the latched sprite.
    for (int i = 0; i < 3000; i++) begin
      int h, v;
      h = ($urandom % 2 == 0) ? mx + int'($urandom_range(0, 60)) - 6
                              : int'($urandom_range(0, 1300));
      v = ($urandom % 2 == 0) ? my + int'($urandom_range(0, 72)) - 4
                              : int'($urandom_range(0, 820));
      pixel(h & 2047, v & 2047, ($urandom % 8 == 0), 12'($urandom));
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      if ($urandom % 30 == 0) vblnk_in = ~vblnk_in;
      if ($urandom % 20 == 0) xpos = ($urandom % 4 == 0) ? 12'($urandom)
                                                          : 12'($urandom_range(0, 1100));
      if ($urandom % 20 == 0) ypos = ($urandom % 4 == 0) ? 12'($urandom)
                                                          : 12'($urandom_range(0, 800));
      rst = ($urandom % 500 == 0);
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/draw_sprite.md
# draw_sprite

Streaming reader for the 48x64 sprite image ROM, inserted into the VGA pixel pipeline between the background generator and the output stage. Converts incoming timing coordinates into the ROM's 12-bit `{y[5:0], x[5:0]}` address, reads back 12-bit RGB, and overlays the sprite at a frame-latched position. Timing signals are delayed to stay aligned with the overlaid colour.

## Interface
Parameters:
- `XPOS_W`, 12, width of requested sprite X position.
- `YPOS_W`, 12, width of requested sprite Y position.

Ports:
- `pclk` in 1: pixel clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `hcount_in`, `vcount_in` in 11 each: current pixel coordinates.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in` in 1 each: VGA timing.
- `rgb_in` in 12: background colour `{r,g,b}`, 4 bits each.
- `xpos`, `ypos` in XPOS_W/YPOS_W: requested sprite top-left corner.
- `rom_addr` out 12: `{dy[5:0], dx[5:0]}` presented to the ROM.
- `rom_rgb` in 12: ROM data; combinational from `rom_addr`.
- `hcount_out`, `vcount_out` out 11 each: delayed coordinates.
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out` out 1 each: delayed timing.
- `rgb_out` out 12: composited colour.

## Operation
- Position latch: `xpos`/`ypos` sampled into `x_lat`/`y_lat` only on the cycle when `vblnk_in` rises (`vblnk_in=1`, previous `vblnk_in=0`). Changes during the active frame take effect from the next frame.
- Stage 1 (registered): compute `dx = hcount_in - x_lat`, `dy = vcount_in - y_lat` in 12 bits. `in_sprite = (hcount_in >= x_lat) && (hcount_in < x_lat+48) && (vcount_in >= y_lat) && (vcount_in < y_lat+64)`. Bounds are compared in 13 bits so `x_lat+48` cannot wrap. Register `rom_addr = {dy[5:0], dx[5:0]}` when `in_sprite` is set, else 0. Register `in_sprite`, `rgb_in`, and all timing/count inputs.
- ROM read: `rom_rgb` is valid in the same cycle as the stage-1 registers.
- Stage 2 (registered): if either stage-1 blank is set, `rgb_out = 0`. Otherwise, if `in_sprite` is set, `rgb_out = rom_rgb`; otherwise `rgb_out` is the delayed `rgb_in`. All timing/count signals are delayed a second time.
- Sprite partly off-screen: pixels beyond the visible area are simply never addressed. No wrap onto the opposite edge.
- `x_lat`/`y_lat` beyond 1023/767: the sprite is invisible and the background passes unchanged.

## Timing
- Latency: 2 `pclk` cycles from any input to the corresponding output, identical for timing, counts and rgb.
- `rom_addr` updates 1 cycle after `hcount_in`/`vcount_in`.
- Reset: on the cycle `rst=1`, all outputs, both pipeline stages, `x_lat` and `y_lat` are cleared to 0, and the previous `vblnk` flag is cleared to 0. The first rising edge of `vblnk_in` after reset loads the position.
- Reset mid-frame: outputs read 0 during reset. After release, the sprite is drawn at (0,0) until the next `vblnk` rise.
- `vblnk` rise and a position change in the same cycle: the new value is captured.

## Configuration
- `DRAW_SPRITE_TRANSPARENCY_EN` defined: a sprite pixel equal to `SPRITE_KEY_COLOR` (12'h0F0) is treated as outside the sprite, and the delayed `rgb_in` is shown instead. The comparison is registered-free, inside stage 2, so latency is unchanged.
- Undefined: every in-bounds sprite pixel overwrites the background, including the key colour.

## Structure
- Shared package holds `SPRITE_W=48`, `SPRITE_H=64`, `SPRITE_KEY_COLOR=12'h0F0`, and `RGB_W=12`.
- Sub-module `vga_timing_delay`: a parameterised N-stage register chain for `{hcount, vcount, hsync, vsync, hblnk, vblnk}` with synchronous reset. It is instantiated with N=2. The rgb/in_sprite path stays in `draw_sprite`.

## Test plan
- Position latch: `xpos=100, ypos=50` set mid-frame → no sprite that frame. After the next `vblnk` rise, the pixel at (100,50) produces `rom_addr=12'h000` and `rgb_out=rom_rgb` 2 cycles later.
- Corner addressing: at (147,113) with the sprite at (100,50) → `rom_addr={6'd63,6'd47}=12'hFEF`. At (148,113) → `rgb_out=rgb_in`.
- Edge clip: `xpos=1000` → columns 1000–1023 are drawn with dx 0–23. No sprite pixels appear at x<48 on the next line.
- Blanking: `hblnk_in=1` inside the sprite box → `rgb_out=0`. All timing outputs equal the inputs delayed by exactly 2 cycles.
- Transparency (macro on): `rom_rgb=12'h0F0`, `rgb_in=12'h123` → `rgb_out=12'h123`. With the macro off → `12'h0F0`.
- Reset mid-frame: assert `rst` for 1 cycle at (500,300) → all outputs are 0 the following cycle, and the sprite appears at (0,0) until the next `vblnk` rise.
